// File: rtl/muldiv_pkg.sv
// Shared types for the ALU multiply/divide unit: FSM states and Booth digit encoding.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Partial-product picker select; encoding matches the mux4to1 input order.
  typedef enum logic [1:0] {
    BOOTH_ZERO = 2'b00,
    BOOTH_A    = 2'b01,
    BOOTH_2A   = 2'b10,
    BOOTH_RSVD = 2'b11
  } booth_sel_t;

endpackage

// File: rtl/booth_mul_seq_if.sv
// Issue/result handshake bundle between operand issue, the Booth multiplier and the result mux.
interface booth_mul_seq_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             a_signed;
  logic             b_signed;
  logic             hi_sel;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, op_a, op_b, a_signed, b_signed, hi_sel, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, a_signed, b_signed, hi_sel, flush, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: {b[2i+1], b[2i], b[2i-1]} -> partial-product select and negate.
module booth_recoder
  import muldiv_pkg::*;
(
  input  logic [2:0] i_bits,
  output booth_sel_t o_sel_c,
  output logic       o_neg_c
);

  always_comb begin
    o_sel_c = BOOTH_ZERO;
    o_neg_c = 1'b0;
    case (i_bits)
      3'b001, 3'b010: o_sel_c = BOOTH_A;
      3'b011:         o_sel_c = BOOTH_2A;
      3'b100: begin
        o_sel_c = BOOTH_2A;
        o_neg_c = 1'b1;
      end
      3'b101, 3'b110: begin
        o_sel_c = BOOTH_A;
        o_neg_c = 1'b1;
      end
      default: o_sel_c = BOOTH_ZERO;
    endcase
  end

endmodule

// File: rtl/mux4to1.sv
// Generic 4:1 mux, used as the Booth partial-product picker.
module mux4to1 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [1:0]       i_sel,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_y_c
);

  always_comb begin
    o_y_c = i_a;
    case (i_sel)
      2'b00:   o_y_c = i_a;
      2'b01:   o_y_c = i_b;
      2'b10:   o_y_c = i_c;
      default: o_y_c = i_d;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier (RV32M MUL/MULH/MULHSU/MULHU), one digit per cycle.
module booth_mul_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  booth_mul_seq_if.slave   bus
);

  localparam int unsigned EXT_W = WIDTH + 2;
  localparam int unsigned ACC_W = 2 * WIDTH + 4;
  localparam int unsigned ITER  = WIDTH / 2 + 1;
  localparam int unsigned CNT_W = $clog2(ITER) + 1;

  mul_state_t         r_state;
  mul_state_t         w_state_nxt;
  logic [EXT_W-1:0]   r_a;
  logic [EXT_W:0]     r_b;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_hi;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic [WIDTH-1:0]   r_result;

  logic               w_accept;
  logic               w_last;
  booth_sel_t         w_sel;
  logic               w_neg;
  logic [EXT_W-1:0]   w_pp;
  logic [EXT_W-1:0]   w_top_sum;
  logic [ACC_W-1:0]   w_acc_sum;
  logic               w_a_sx;
  logic               w_b_sx;

  // flush takes priority over a simultaneous in_valid
  assign w_accept = bus.in_valid & r_in_ready & ~bus.flush;
  assign w_last   = (r_cnt == CNT_W'(ITER - 1));
  assign w_a_sx   = bus.a_signed & bus.op_a[WIDTH-1];
  assign w_b_sx   = bus.b_signed & bus.op_b[WIDTH-1];

  booth_recoder u_recoder (
    .i_bits  (r_b[2:0]),
    .o_sel_c (w_sel),
    .o_neg_c (w_neg)
  );

  mux4to1 #(
    .WIDTH (EXT_W)
  ) u_pp_mux (
    .i_sel (w_sel),
    .i_a   ('0),
    .i_b   (r_a),
    .i_c   ({r_a[EXT_W-2:0], 1'b0}),
    .i_d   ('0),
    .o_y_c (w_pp)
  );

  // Partial product lands on the top EXT_W bits; the running sum never exceeds 2|A| so no overflow.
  assign w_top_sum = r_acc[ACC_W-1 -: EXT_W] + (w_neg ? ~w_pp : w_pp) + EXT_W'(w_neg);
  assign w_acc_sum = {w_top_sum, r_acc[EXT_W-1:0]};

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_state_nxt = RUN;
        RUN:     if (w_last) w_state_nxt = DONE;
        DONE:    if (r_out_valid && bus.out_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_busy      <= (w_state_nxt != IDLE);
      // first DONE cycle captures the product; valid rises one edge later
      r_out_valid <= (r_state == DONE) && (w_state_nxt == DONE);
      if ((r_state == DONE) && !r_out_valid && !bus.flush) begin
        r_result <= r_hi ? r_acc[2*WIDTH-1 -: WIDTH] : r_acc[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_hi  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= {w_a_sx, w_a_sx, bus.op_a};
      r_b   <= {w_b_sx, w_b_sx, bus.op_b, 1'b0};
      r_acc <= '0;
      r_cnt <= '0;
      r_hi  <= bus.hi_sel;
    end else if (r_state == RUN) begin
      r_acc <= ACC_W'($signed(w_acc_sum) >>> 2);
      r_b   <= {r_b[EXT_W], r_b[EXT_W], r_b[EXT_W:2]};
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.result    = r_result;

endmodule
